twiddle_sequencer: RTL

Address sequencer for one R2²SDF butterfly stage's twiddle path. Counts accepted samples within each N-point frame, generates the twiddle number for every sample, and presents it to the 1/8-size twiddle ROM and octant converter. Delays the enable, frame markers and bypass flag so they arrive on the same cycle as the converted twiddle value at the complex multiplier.

---
 rtl/r22sdf_pkg.sv | 17 +
 rtl/twiddle_sequencer_if.sv | 24 ++
 rtl/delay_line.sv | 36 +++
 rtl/twiddle_sequencer.sv | 100 ++++++++++
 4 files changed

// File: rtl/r22sdf_pkg.sv
// Shared definitions for the R2^2 SDF stage: quarter multipliers, FSM encoding
// and the twiddle path latency used to align the data path.
package r22sdf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Twiddle multiplier k for quarters q = 0..3 is 0, 2, 1, 3 (element [q]).
  localparam logic [3:0][1:0] QUARTER_K = {2'd3, 2'd1, 2'd2, 2'd0};

  function automatic int latency(input int rom_ff, input int tc_ff);
    return 1 + rom_ff + tc_ff;
  endfunction

endpackage

// File: rtl/twiddle_sequencer_if.sv
// Sample-enable inputs and twiddle/control outputs of one sequencer.
interface twiddle_sequencer_if #(
  parameter int LOG_N = 6
);
  logic             di_en;
  logic             clear;
  logic [LOG_N-1:0] tw_addr;
  logic             tw_en;
  logic             do_en;
  logic             do_first;
  logic             do_last;
  logic             do_bypass;
  logic             busy;

  modport master (
    output di_en, clear,
    input  tw_addr, tw_en, do_en, do_first, do_last, do_bypass, busy
  );

  modport slave (
    input  di_en, clear,
    output tw_addr, tw_en, do_en, do_first, do_last, do_bypass, busy
  );
endinterface

// File: rtl/delay_line.sv
// Fixed-depth shift register; DEPTH = 0 degenerates to a wire.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      wire unused_ok = &{1'b0, clock, reset_n};
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] pipe [DEPTH];

      // NOTE: every stage is reset, not just the output, so samples in flight
      // disappear on reset instead of emerging as stale enables afterwards.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
          // NOTE: non-blocking assignments let every stage sample the old
          // value of its neighbour, so the chain shifts by exactly one.
          pipe[0] <= din;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dout = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/twiddle_sequencer.sv
// Twiddle address sequencer for one R2^2 SDF stage: frame counter, shift/add
// twiddle number, and control flags delayed to meet the converted twiddle.
module twiddle_sequencer
  import r22sdf_pkg::*;
#(
  parameter int LOG_N  = 6,
  parameter int ROM_FF = 1,
  parameter int TC_FF  = 1
) (
  input logic               clock,
  input logic               reset_n,
  twiddle_sequencer_if.slave bus
);

  localparam int QW  = LOG_N - 2;
  localparam int DLY = latency(ROM_FF, TC_FF) - 1;
  localparam logic [LOG_N-1:0] ONE = LOG_N'(1);

  state_t           state, state_nxt;
  logic [LOG_N-1:0] cnt, cnt_nxt;
  logic [LOG_N-1:0] idx, m_ext, addr;
  logic [1:0]       q, k;
  logic [QW-1:0]    m;
  logic             first, last, bypass;

  logic [LOG_N-1:0] tw_addr_q;
  logic             tw_en_q, first_q, last_q, bypass_q;
  logic [3:0]       dly_out;

  // A sample accepted together with clear is index 0 of a new frame.
  assign idx   = bus.clear ? '0 : cnt;
  assign q     = idx[LOG_N-1 -: 2];
  assign m     = idx[QW-1:0];
  assign m_ext = {2'b00, m};
  assign k     = QUARTER_K[q];

  assign addr   = (k[1] ? (m_ext << 1) : '0) + (k[0] ? m_ext : '0);
  assign bypass = (q == 2'd0) || (m == '0);
  assign first  = (idx == '0);
  assign last   = &idx;

  always_comb begin
    // NOTE: defaults first, so every path assigns both outputs and no latch
    // is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    if (bus.clear) begin
      state_nxt = bus.di_en ? RUN : IDLE;
      cnt_nxt   = bus.di_en ? ONE : '0;
    end else if (bus.di_en) begin
      unique case (state)
        IDLE: begin
          state_nxt = RUN;
          cnt_nxt   = ONE;
        end
        RUN: begin
          cnt_nxt   = cnt + ONE;
          state_nxt = (&cnt) ? IDLE : RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tw_addr_q <= '0;
      tw_en_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      bypass_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tw_en_q  <= bus.di_en;
      first_q  <= bus.di_en & first;
      last_q   <= bus.di_en & last;
      bypass_q <= bus.di_en & bypass;
      if (bus.di_en) tw_addr_q <= addr;
    end
  end

  delay_line #(
    .WIDTH (4),
    .DEPTH (DLY)
  ) u_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .din     ({tw_en_q, first_q, last_q, bypass_q}),
    .dout    (dly_out)
  );

  assign bus.tw_addr = tw_addr_q;
  assign bus.tw_en   = tw_en_q;
  assign {bus.do_en, bus.do_first, bus.do_last, bus.do_bypass} = dly_out;
  assign bus.busy    = (state == RUN);

endmodule
